// File: rtl/mux_arbiter_if.sv
// Request/data/grant bundle between up to four requesters and the shared
// 4:1 multiplexer arbiter.
interface mux_arbiter_if #(
  parameter int unsigned DW = 8
);
  logic [3:0]      req;
  logic [4*DW-1:0] din;
  logic [3:0]      gnt;
  logic [1:0]      sel;
  logic [DW-1:0]   dout;
  logic            dout_vld;

  // Requester side
  modport master (
    output req, din,
    input  gnt, sel, dout, dout_vld
  );

  // Arbiter side
  modport slave (
    input  req, din,
    output gnt, sel, dout, dout_vld
  );
endinterface

// File: rtl/mux_arbiter.sv
// Round-robin arbiter with per-grant time slice driving a registered 4:1 mux.
// Grant, select, data and valid are all registered.
module mux_arbiter #(
  parameter int unsigned DW    = 8,
  parameter int unsigned SLICE = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  mux_arbiter_if.slave bus
);

  localparam int unsigned NREQ = 4;
  localparam int unsigned IW   = 2;
  localparam int unsigned CW   = 8;

  typedef enum logic [0:0] {IDLE, BUSY} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   ptr, ptr_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [NREQ-1:0] gnt, gnt_nxt;
  logic [IW-1:0]   sel, sel_nxt;
  logic [DW-1:0]   dout, dout_nxt;
  logic            dout_vld, dout_vld_nxt;

  logic [DW-1:0]   din_sel;
  logic            owner_req;
  logic            slice_done;
  logic [IW-1:0]   start;
  logic [IW-1:0]   winner;

  // First requesting index at or after start, wrapping mod 4.
  function automatic logic [IW-1:0] search(input logic [NREQ-1:0] r,
                                           input logic [IW-1:0]   s);
    logic [IW-1:0] idx;
    search = s;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = s + IW'(k);
      if (r[idx]) search = idx;
    end
  endfunction

  // Current owner's data lane.
  always_comb begin
    din_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel == IW'(i)) din_sel = bus.din[i*DW +: DW];
    end
  end

  assign owner_req  = bus.req[sel];
  assign slice_done = (cnt == CW'(SLICE));
  // On release the search restarts just past the owner; in IDLE it uses ptr.
  assign start      = (state == BUSY) ? sel + IW'(1) : ptr;
  assign winner     = search(bus.req, start);

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    cnt_nxt      = cnt;
    gnt_nxt      = gnt;
    sel_nxt      = sel;
    dout_nxt     = dout;
    dout_vld_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (|bus.req) begin
          gnt_nxt   = NREQ'(1) << winner;
          sel_nxt   = winner;
          cnt_nxt   = CW'(1);
          state_nxt = BUSY;
        end else begin
          gnt_nxt = '0;
        end
      end
      BUSY: begin
        if (owner_req) begin
          dout_nxt     = din_sel;
          dout_vld_nxt = 1'b1;
        end
        // A drop coinciding with slice expiry is a single release.
        if (!owner_req || slice_done) begin
          ptr_nxt = sel + IW'(1);
          if (|bus.req) begin
            gnt_nxt = NREQ'(1) << winner;
            sel_nxt = winner;
            cnt_nxt = CW'(1);
          end else begin
            gnt_nxt   = '0;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        gnt_nxt   = '0;
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      cnt      <= '0;
      gnt      <= '0;
      sel      <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      cnt      <= cnt_nxt;
      gnt      <= gnt_nxt;
      sel      <= sel_nxt;
      dout     <= dout_nxt;
      dout_vld <= dout_vld_nxt;
    end
  end

  assign bus.gnt      = gnt;
  assign bus.sel      = sel;
  assign bus.dout     = dout;
  assign bus.dout_vld = dout_vld;

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed and random checks of mux_arbiter against a cycle model and a
// scoreboard of expected registered outputs.
module tb_mux_arbiter;

  localparam int unsigned DW    = 8;
  localparam int unsigned SLICE = 8;

  typedef struct {
    logic [3:0]    gnt;
    logic [1:0]    sel;
    logic [DW-1:0] dout;
    logic          vld;
  } exp_t;

  logic clk;
  logic rst_n;

  mux_arbiter_if #(.DW(DW)) bus ();

  mux_arbiter #(.DW(DW), .SLICE(SLICE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;
  exp_t sb[$];

  // Reference model state
  int            m_own;
  int            m_ptr;
  int            m_cnt;
  logic [1:0]    m_sel;
  logic [DW-1:0] m_dout;
  logic          m_vld;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_own  = -1;
    m_ptr  = 0;
    m_cnt  = 0;
    m_sel  = '0;
    m_dout = '0;
    m_vld  = 1'b0;
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  // Advance the model one edge and queue the outputs it predicts.
  task automatic model_step(input logic [3:0] r, input logic [4*DW-1:0] d);
    exp_t e;
    if (m_own >= 0 && r[m_own]) begin
      m_dout = d[m_own*DW +: DW];
      m_vld  = 1'b1;
    end else begin
      m_vld = 1'b0;
    end
    if (m_own < 0) begin
      if (r != 4'b0000) begin
        m_own = pick(r, m_ptr);
        m_cnt = 1;
      end
    end else if (!r[m_own] || m_cnt == int'(SLICE)) begin
      m_ptr = (m_own + 1) % 4;
      if (r != 4'b0000) begin
        m_own = pick(r, m_ptr);
        m_cnt = 1;
      end else begin
        m_own = -1;
        m_cnt = 0;
      end
    end else begin
      m_cnt++;
    end
    if (m_own >= 0) m_sel = 2'(m_own);
    e.gnt  = (m_own >= 0) ? (4'b0001 << m_own) : 4'b0000;
    e.sel  = m_sel;
    e.dout = m_dout;
    e.vld  = m_vld;
    sb.push_back(e);
  endtask

  // Drive one cycle at the falling edge, check the result one falling edge later.
  task automatic step(input logic [3:0] r, input logic [4*DW-1:0] d);
    exp_t e;
    bus.req = r;
    bus.din = d;
    model_step(r, d);
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("sb_gnt",  32'(bus.gnt),      32'(e.gnt));
      check("sb_sel",  32'(bus.sel),      32'(e.sel));
      check("sb_dout", 32'(bus.dout),     32'(e.dout));
      check("sb_vld",  32'(bus.dout_vld), 32'(e.vld));
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    bus.req = 4'b0000;
    model_reset();
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [4*DW-1:0] lane(input int i, input logic [DW-1:0] v);
    logic [4*DW-1:0] d;
    d = '0;
    d[i*DW +: DW] = v;
    return d;
  endfunction

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    model_reset();

    // Reset held with all requests asserted
    rst_n   = 1'b0;
    bus.req = 4'b1111;
    bus.din = {4{8'h5A}};
    repeat (3) begin
      @(negedge clk);
      check("rst_gnt",  32'(bus.gnt),      32'h0);
      check("rst_sel",  32'(bus.sel),      32'h0);
      check("rst_dout", 32'(bus.dout),     32'h0);
      check("rst_vld",  32'(bus.dout_vld), 32'h0);
    end
    bus.req = 4'b0000;
    rst_n   = 1'b1;

    // Single requester on lane 2
    step(4'b0100, lane(2, 8'hA5));
    check("single_gnt", 32'(bus.gnt), 32'h4);
    check("single_sel", 32'(bus.sel), 32'h2);
    check("single_vld0", 32'(bus.dout_vld), 32'h0);
    for (int i = 0; i < 2; i++) begin
      step(4'b0100, lane(2, 8'hA5));
      check("single_dout", 32'(bus.dout), 32'hA5);
      check("single_vld",  32'(bus.dout_vld), 32'h1);
    end
    step(4'b0000, lane(2, 8'hA5));
    check("single_idle_gnt", 32'(bus.gnt), 32'h0);
    check("single_idle_vld", 32'(bus.dout_vld), 32'h0);
    check("single_idle_sel", 32'(bus.sel), 32'h2);

    // Full contention rotates 0,1,2,3,0 with SLICE cycles each
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      step(4'b1111, {8'(k + 3), 8'(k + 2), 8'(k + 1), 8'(k)});
      check("rotate_gnt", 32'(bus.gnt), 32'(4'b0001 << (((k - 1) / int'(SLICE)) % 4)));
    end
    step(4'b0000, '0);

    // Sole requester keeps the grant across slice expiries
    for (int k = 0; k < 20; k++) begin
      step(4'b0001, lane(0, 8'(8'h30 + k)));
      check("sole_gnt", 32'(bus.gnt), 32'h1);
    end
    step(4'b0000, '0);

    // Early release by owner 1 hands over to requester 3, slice restarts
    do_reset();
    step(4'b0010, lane(1, 8'h11));
    check("early_own1", 32'(bus.gnt), 32'h2);
    step(4'b1010, lane(1, 8'h12));
    step(4'b1010, lane(1, 8'h13));
    step(4'b1000, lane(3, 8'h33));
    check("early_gnt", 32'(bus.gnt), 32'h8);
    check("early_sel", 32'(bus.sel), 32'h3);
    for (int k = 0; k < int'(SLICE) - 1; k++) begin
      step(4'b1001, lane(3, 8'(8'h40 + k)));
      check("early_hold", 32'(bus.gnt), 32'h8);
    end
    step(4'b1001, lane(0, 8'h77));
    check("early_slice_end", 32'(bus.gnt), 32'h1);
    step(4'b0000, '0);

    // Asynchronous reset while requester 2 owns the path
    repeat (3) step(4'b0100, lane(2, 8'hC3));
    check("async_pre_gnt", 32'(bus.gnt), 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_gnt",  32'(bus.gnt),      32'h0);
    check("async_sel",  32'(bus.sel),      32'h0);
    check("async_dout", 32'(bus.dout),     32'h0);
    check("async_vld",  32'(bus.dout_vld), 32'h0);
    model_reset();
    sb.delete();
    bus.req = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1111, {8'h04, 8'h03, 8'h02, 8'h01});
    check("async_first", 32'(bus.gnt), 32'h1);

    // Random traffic against the model
    for (int k = 0; k < 150; k++) begin
      step(4'($urandom_range(0, 15)), 32'($urandom));
      check("onehot", 32'($countones(bus.gnt) <= 1), 32'h1);
      if (bus.gnt != 4'b0000)
        check("sel_match", 32'(4'b0001 << bus.sel), 32'(bus.gnt));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Round-robin arbiter and registered output stage for a shared 4:1 multiplexer path. Up to four requesters compete for one output channel; the block grants one requester at a time, drives the multiplexer select, and registers the selected data. A per-grant time slice bounds how long one requester may hold the path while others wait.

## Interface
- `DW`, 8: data width per requester.
- `SLICE`, 8: maximum consecutive grant cycles per requester, range 1..255.
- `clk`  input  1  system clock, rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `req`  input  4  request per requester; bit i = requester i.
- `din`  input  4*DW  concatenated data; requester i occupies `din[i*DW +: DW]`.
- `gnt`  output  4  one-hot grant, or all-zero when idle; registered.
- `sel`  output  2  index of current or last owner; drives the multiplexer select; registered.
- `dout`  output  DW  registered multiplexer output.
- `dout_vld`  output  1  `dout` holds a beat captured from the owner; registered.

## Operation
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset values: state=IDLE, `gnt`=0, `sel`=0, `dout`=0, `dout_vld`=0, rotation pointer `ptr`=0, slice counter `cnt`=0.
- Winner search: starting at index `ptr`, check indices ptr, ptr+1, ptr+2, ptr+3, wrapping mod 4. The first index with `req` set wins.
- IDLE state:
  - If `req`≠0: grant the search winner `w`. Set `gnt`=1<<w, `sel`=w, `cnt`=1, and go to BUSY.
  - Otherwise stay in IDLE with `gnt`=0.
- BUSY state, owner `o`:
  - Release condition: `req[o]`=0, or `cnt`==SLICE.
  - On release: `ptr`←(o+1) mod 4, and the search runs from (o+1) mod 4 on the same edge.
    - If any `req` is set: grant the new winner and set `cnt`=1. The state stays BUSY with no idle gap.
    - Otherwise: go to IDLE with `gnt`=0.
  - No release: `cnt`←`cnt`+1. `gnt` and `sel` are unchanged.
- Sole requester at slice expiry: the search returns `o` again. `gnt` stays asserted continuously and `cnt` restarts at 1.
- Data path: on each edge where the state is BUSY and `req[o]`=1:
  - `dout`←`din[o]`, `dout_vld`←1.
  - Otherwise `dout_vld`←0 and `dout` holds its value.
- `sel` holds the last owner while IDLE.
- Requester rules:
  - Requesters hold `req` until granted.
  - A `req` dropped before its grant is ignored, with no error.
  - The owner may drop `req` at any cycle.
- Fairness: a continuously requesting requester waits at most 3×SLICE cycles for a grant.

## Timing
- Grant latency: `req` sampled high in IDLE gives `gnt` on the next edge (1 cycle).
- Handover: owner drops `req` in cycle t, so `gnt` moves to the next winner at the end of cycle t. Cycle t itself shows `gnt[o]`=1, `req[o]`=0, and no data beat.
- Data latency: `din[o]` present in a cycle with `gnt[o]`=1 and `req[o]`=1 appears on `dout` with `dout_vld`=1 one cycle later.
- Simultaneous events:
  - Release and new requests on the same edge: new requests participate in that edge's search.
  - Slice expiry coinciding with the owner dropping `req`: treated as one release.
- Reset mid-grant: all outputs and state clear immediately and asynchronously. After `rst_n` deasserts, `ptr`=0, so index 0 has first priority.
- `gnt` is never multi-hot. `sel` always equals the index of the set `gnt` bit whenever `gnt`≠0.

## Test plan
- Reset: assert `rst_n`=0 with `req`=4'b1111 → `gnt`=0, `sel`=0, `dout`=0, `dout_vld`=0, held throughout reset.
- Single requester: `req`=4'b0100 for 3 cycles, `din[2]`=8'hA5 → `gnt`=4'b0100 and `sel`=2 one cycle after `req`. `dout`=8'hA5 with `dout_vld`=1 for 2 cycles, lagging by one cycle. Then `gnt`=0 and state is IDLE.
- Full contention, SLICE=8: `req`=4'b1111 held → grants rotate 0,1,2,3,0 with exactly 8 cycles each and no gap cycles.
- Sole requester past slice: `req`=4'b0001 for 20 cycles → `gnt`=4'b0001 continuously, with no deassert at cycles 8 or 16.
- Early release: owner 1 drops `req` after 3 cycles while `req[3]`=1 → `gnt`=4'b1000 on the next edge, `sel`=3, `cnt` restarts at 1.
- Async reset mid-grant: owner 2 active, pulse `rst_n` low off-edge → outputs clear immediately. After release with `req`=4'b1111, the first grant is 4'b0001.
